// File: rtl/aes_pkg.sv
// Shared AES constants, key-schedule state encoding and the round-constant table.
package aes_pkg;

  localparam int AES_NK     = 4;
  localparam int AES_NR_MAX = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } ks_state_e;

  // Rcon[rnd] top byte; rounds outside 1..10 contribute nothing.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, one byte in and one byte out.
// Shared between the key schedule's SubWord and the cipher's SubBytes.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] in_i,
  output logic [7:0] out_o
);

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign out_o = SBOX[in_i];

endmodule

// File: rtl/aes_key_schedule_seq.sv
// Iterative AES-128 key expansion: one round key per clock into a register file
// that is presented flattened as the encrypt stage's fullkeys bus.
module aes_key_schedule_seq
  import aes_pkg::*;
#(
  parameter int Nk = AES_NK,
  parameter int Nr = AES_NR_MAX
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [127:0]           key,
  input  logic                   key_valid,
  output logic                   key_ready,
  output logic [128*(Nr+1)-1:0]  fullkeys,
  output logic                   keys_valid,
  output logic                   busy
);

  if (Nk != 4) begin : g_bad_nk
    $error("aes_key_schedule_seq: only Nk=4 (AES-128) is supported");
  end
  if (Nr < 1 || Nr > AES_NR_MAX) begin : g_bad_nr
    $error("aes_key_schedule_seq: Nr must be within 1..10");
  end

  ks_state_e    state_q;
  logic [3:0]   rnd_q;
  logic [127:0] rk_q [Nr+1];
  logic         keyReady_q;
  logic         keysValid_q;
  logic         busy_q;

  logic [127:0] prevKey;
  logic [127:0] nextRoundKey_d;
  logic [31:0]  rotWord;
  logic [31:0]  subWord;
  logic [31:0]  temp;
  logic [31:0]  n0, n1, n2, n3;

  // Slot rnd-1 feeds the round step; rnd never exceeds Nr while expanding.
  always_comb begin
    prevKey = rk_q[0];
    for (int i = 1; i < Nr; i++) begin
      if (rnd_q == 4'(i + 1)) prevKey = rk_q[i];
    end
  end

  assign rotWord = {prevKey[23:0], prevKey[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_subword
    aes_sbox u_sbox (
      .in_i  (rotWord[8*g +: 8]),
      .out_o (subWord[8*g +: 8])
    );
  end

  always_comb begin
    temp           = subWord ^ {rcon(rnd_q), 24'h0};
    n0             = prevKey[127:96] ^ temp;
    n1             = prevKey[95:64]  ^ n0;
    n2             = prevKey[63:32]  ^ n1;
    n3             = prevKey[31:0]   ^ n2;
    nextRoundKey_d = {n0, n1, n2, n3};
  end

  // Accepting a key reloads slot 0 and clears the rest so stale rounds never leak.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rnd_q       <= 4'd0;
      keyReady_q  <= 1'b1;
      keysValid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int i = 0; i <= Nr; i++) rk_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (key_valid && keyReady_q) begin
            rk_q[0] <= key;
            for (int i = 1; i <= Nr; i++) rk_q[i] <= '0;
            rnd_q       <= 4'd1;
            state_q     <= EXPAND;
            keyReady_q  <= 1'b0;
            keysValid_q <= 1'b0;
            busy_q      <= 1'b1;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= Nr; i++) begin
            if (rnd_q == 4'(i)) rk_q[i] <= nextRoundKey_d;
          end
          rnd_q <= rnd_q + 4'd1;
          if (rnd_q == 4'(Nr)) begin
            state_q     <= DONE;
            keysValid_q <= 1'b1;
            keyReady_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar g = 0; g <= Nr; g++) begin : g_flatten
    assign fullkeys[128*(Nr+1-g)-1 -: 128] = rk_q[g];
  end

  assign key_ready  = keyReady_q;
  assign keys_valid = keysValid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_aes_key_schedule_seq.sv
// Self-checking bench: a 10-round and a 1-round key schedule against a
// FIPS-197 style word-expansion model built from GF(2^8) arithmetic.
module tb_aes_key_schedule_seq;

  logic            clk;
  logic            rst;
  logic [127:0]    keyIn;
  logic            keyValidA, keyValidB;
  logic            keyReadyA, keyReadyB;
  logic            keysValidA, keysValidB;
  logic            busyA, busyB;
  logic [1407:0]   fullkeysA;
  logic [255:0]    fullkeysB;

  int errors = 0;
  int checks = 0;

  logic [7:0]   refSbox [256];
  logic [127:0] refKeys [0:10];

  aes_key_schedule_seq #(.Nk(4), .Nr(10)) dutA (
    .clk        (clk),
    .rst        (rst),
    .key        (keyIn),
    .key_valid  (keyValidA),
    .key_ready  (keyReadyA),
    .fullkeys   (fullkeysA),
    .keys_valid (keysValidA),
    .busy       (busyA)
  );

  aes_key_schedule_seq #(.Nk(4), .Nr(1)) dutB (
    .clk        (clk),
    .rst        (rst),
    .key        (keyIn),
    .key_valid  (keyValidB),
    .key_ready  (keyReadyB),
    .fullkeys   (fullkeysB),
    .keys_valid (keysValidB),
    .busy       (busyB)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Reference arithmetic: GF(2^8) multiply, inverse and the S-box affine map.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic buildSbox();
    logic [7:0] inv;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int c = 1; c < 256; c++) begin
        if (gfMul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
      end
      refSbox[v] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] refSubWord(input logic [31:0] w);
    return {refSbox[w[31:24]], refSbox[w[23:16]], refSbox[w[15:8]], refSbox[w[7:0]]};
  endfunction

  task automatic expandRef(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = k[127:96]; w[1] = k[95:64]; w[2] = k[63:32]; w[3] = k[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = refSubWord({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gfMul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) refKeys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] slotA(input int i);
    return fullkeysA[128*(11-i)-1 -: 128];
  endfunction

  function automatic logic [127:0] slotB(input int i);
    return fullkeysB[128*(2-i)-1 -: 128];
  endfunction

  function automatic logic [127:0] randKey();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic applyStimulus(input logic [127:0] k, input bit toB);
    keyIn = k;
    if (toB) keyValidB = 1'b1;
    else     keyValidA = 1'b1;
    @(negedge clk);
    keyValidA = 1'b0;
    keyValidB = 1'b0;
  endtask

  task automatic expandAndCheckA(input string name, input logic [127:0] k, input bit noisy);
    expandRef(k);
    applyStimulus(k, 1'b0);
    checkOutput({name, ".accept.keys_valid"}, 128'(keysValidA), 128'd0);
    checkOutput({name, ".accept.key_ready"}, 128'(keyReadyA), 128'd0);
    checkOutput({name, ".accept.busy"}, 128'(busyA), 128'd1);
    checkOutput({name, ".accept.slot0"}, slotA(0), k);
    checkOutput({name, ".accept.slot1"}, slotA(1), 128'd0);
    checkOutput({name, ".accept.slot10"}, slotA(10), 128'd0);
    for (int c = 1; c <= 10; c++) begin
      if (noisy) begin
        keyIn     = randKey();
        keyValidA = (c % 2 == 1);
      end
      @(negedge clk);
      keyValidA = 1'b0;
      checkOutput($sformatf("%s.round%0d", name, c), slotA(c), refKeys[c]);
      checkOutput($sformatf("%s.keys_valid@%0d", name, c), 128'(keysValidA), 128'(c == 10));
    end
    for (int r = 0; r <= 10; r++) begin
      checkOutput($sformatf("%s.final.slot%0d", name, r), slotA(r), refKeys[r]);
    end
    checkOutput({name, ".done.key_ready"}, 128'(keyReadyA), 128'd1);
    checkOutput({name, ".done.busy"}, 128'(busyA), 128'd0);
  endtask

  task automatic expandAndCheckB(input string name, input logic [127:0] k);
    expandRef(k);
    applyStimulus(k, 1'b1);
    checkOutput({name, ".accept.keys_valid"}, 128'(keysValidB), 128'd0);
    checkOutput({name, ".accept.busy"}, 128'(busyB), 128'd1);
    @(negedge clk);
    checkOutput({name, ".keys_valid"}, 128'(keysValidB), 128'd1);
    checkOutput({name, ".key_ready"}, 128'(keyReadyB), 128'd1);
    checkOutput({name, ".slot0"}, slotB(0), k);
    checkOutput({name, ".slot1"}, slotB(1), refKeys[1]);
  endtask

  initial begin
    logic [127:0] fipsKey;
    fipsKey   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    rst       = 1'b1;
    keyIn     = '0;
    keyValidA = 1'b0;
    keyValidB = 1'b0;
    buildSbox();

    repeat (2) @(negedge clk);
    checkOutput("reset.key_ready", 128'(keyReadyA), 128'd1);
    checkOutput("reset.keys_valid", 128'(keysValidA), 128'd0);
    checkOutput("reset.busy", 128'(busyA), 128'd0);
    for (int r = 0; r <= 10; r++) checkOutput($sformatf("reset.slot%0d", r), slotA(r), 128'd0);
    checkOutput("reset.B.fullkeys", fullkeysB[255:128] | fullkeysB[127:0], 128'd0);
    checkOutput("reset.B.key_ready", 128'(keyReadyB), 128'd1);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] FIPS-197 A.1 key");
    expandAndCheckA("fips", fipsKey, 1'b0);
    checkOutput("fips.round1.const", slotA(1), 128'ha0fafe1788542cb123a339392a6c7605);
    checkOutput("fips.round10.const", slotA(10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    $display("[TB] all-zero key, accepted back-to-back from DONE");
    expandAndCheckA("zero", 128'd0, 1'b0);
    checkOutput("zero.round1.const", slotA(1), 128'h62636363626363636263636362636363);
    checkOutput("zero.round10.const", slotA(10), 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    $display("[TB] random keys with key_valid pulses during expansion");
    for (int n = 0; n < 4; n++) expandAndCheckA($sformatf("rand%0d", n), randKey(), 1'b1);

    $display("[TB] reset four clocks into an expansion");
    applyStimulus(randKey(), 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset.keys_valid", 128'(keysValidA), 128'd0);
    checkOutput("midreset.key_ready", 128'(keyReadyA), 128'd1);
    checkOutput("midreset.busy", 128'(busyA), 128'd0);
    for (int r = 0; r <= 10; r++) checkOutput($sformatf("midreset.slot%0d", r), slotA(r), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    expandAndCheckA("afterreset", randKey(), 1'b0);

    $display("[TB] single-round build");
    expandAndCheckB("nr1.fips", fipsKey);
    checkOutput("nr1.fips.const", fullkeysB[127:0], 128'ha0fafe1788542cb123a339392a6c7605);
    for (int n = 0; n < 3; n++) expandAndCheckB($sformatf("nr1.rand%0d", n), randKey());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
